cache_ctrl: RTL and testbench

Sequencing controller for the 2-way set-associative cache way array (8 sets × 2 ways × 256-bit blocks). It owns the tag, valid and LRU state and drives the way array's `index`, `write[1:0]`, `WF[1:0]` and `inblock`. It serves single-word CPU loads and stores: read-allocate, write-through, no-write-allocate. Misses refill over a request/acknowledge memory port.

---
 rtl/cache_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_cache_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl.sv
// cache_ctrl
// Sequencing controller for a 2-way set-associative cache way array
// (8 sets x 2 ways x 256-bit blocks). Owns tag/valid/LRU state and serves
// single-word CPU loads and stores: read-allocate, write-through,
// no-write-allocate. Misses refill over a request/acknowledge memory port.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   cpu_req/we/addr/wdata  CPU request; addr[4:2] word, [7:5] index, [31:8] tag
//   cpu_ready/rdata   one-cycle completion pulse, load data (held until next load)
//   way_index/write/wf/inblock, way_outblock   way array control and data
//   mem_req/we/addr/wdata, mem_ack/rdata       memory port (block read / word write)
//   hit_count/miss_count  saturating statistics counters
//
// Build option: define CACHE_STATS_EN to include the hit/miss counters;
// otherwise hit_count and miss_count are tied to zero.
module cache_ctrl #(
    parameter int TAG_W = 24,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [31:0]      cpu_addr,
    input  logic [31:0]      cpu_wdata,
    output logic             cpu_ready,
    output logic [31:0]      cpu_rdata,
    output logic [2:0]       way_index,
    output logic [1:0]       way_write,
    output logic [1:0]       way_wf,
    output logic [255:0]     way_inblock,
    input  logic [255:0]     way_outblock,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic             mem_ack,
    input  logic [255:0]     mem_rdata,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    typedef enum logic [2:0] {
        IDLE, TAG, ACCESS, MERGE, FILL, MEMWR, DONE
    } state_t;

    state_t           state_q, state_d;
    logic [31:2]      addr_q, addr_d;
    logic             we_q, we_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             hitWay_q, hitWay_d;
    logic [255:0]     block_q, block_d;
    logic [31:0]      rdata_q, rdata_d;

    logic [TAG_W-1:0] tag_q [2][8];
    logic [7:0]       valid_q [2];
    logic [7:0]       lru_q;

    logic [2:0]       setIdx;
    logic [2:0]       wordSel;
    logic [TAG_W-1:0] reqTag;
    logic             hit0, hit1, anyHit;
    logic             victim;
    logic             fillEn, lruEn;

    // Byte offset bits never matter: loads and stores are whole words.
    logic             unusedBits;
    assign unusedBits = ^cpu_addr[1:0];

    assign setIdx  = addr_q[7:5];
    assign wordSel = addr_q[4:2];
    assign reqTag  = addr_q[31:32-TAG_W];

    assign hit0   = valid_q[0][setIdx] && (tag_q[0][setIdx] == reqTag);
    assign hit1   = valid_q[1][setIdx] && (tag_q[1][setIdx] == reqTag);
    assign anyHit = hit0 | hit1;

    // Prefer an empty way; only fall back to LRU when both ways are occupied.
    assign victim = !valid_q[0][setIdx] ? 1'b0 :
                    !valid_q[1][setIdx] ? 1'b1 : lru_q[setIdx];

    assign cpu_ready = (state_q == DONE);
    assign cpu_rdata = rdata_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        hitWay_d    = hitWay_q;
        block_d     = block_q;
        rdata_d     = rdata_q;
        fillEn      = 1'b0;
        lruEn       = 1'b0;
        way_write   = 2'b00;
        way_wf      = 2'b00;
        way_inblock = '0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        way_index   = (state_q == IDLE) ? cpu_addr[7:5] : setIdx;

        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    addr_d  = cpu_addr[31:2];
                    we_d    = cpu_we;
                    wdata_d = cpu_wdata;
                    state_d = TAG;
                end
            end
            TAG: begin
                hitWay_d = hit1 & ~hit0;
                if (anyHit)    state_d = ACCESS;
                else if (we_q) state_d = MEMWR;
                else           state_d = FILL;
            end
            ACCESS: begin
                way_wf = hitWay_q ? 2'b10 : 2'b01;
                lruEn  = 1'b1;
                if (we_q) begin
                    block_d = way_outblock;
                    block_d[{wordSel, 5'd0} +: 32] = wdata_q;
                    state_d = MERGE;
                end else begin
                    rdata_d = way_outblock[{wordSel, 5'd0} +: 32];
                    state_d = DONE;
                end
            end
            MERGE: begin
                way_inblock = block_q;
                way_write   = hitWay_q ? 2'b10 : 2'b01;
                state_d     = MEMWR;
            end
            FILL: begin
                mem_req  = 1'b1;
                mem_addr = {addr_q[31:5], 5'd0};
                if (mem_ack) begin
                    // Refill goes straight into the way; ACCESS re-reads it to serve the load.
                    way_inblock = mem_rdata;
                    way_write   = victim ? 2'b10 : 2'b01;
                    fillEn      = 1'b1;
                    hitWay_d    = victim;
                    state_d     = ACCESS;
                end
            end
            MEMWR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {addr_q, 2'b00};
                mem_wdata = wdata_q;
                if (mem_ack) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            hitWay_q <= 1'b0;
            block_q  <= '0;
            rdata_q  <= '0;
            lru_q    <= '0;
            for (int w = 0; w < 2; w++) begin
                valid_q[w] <= '0;
                for (int s = 0; s < 8; s++) begin
                    tag_q[w][s] <= '0;
                end
            end
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            hitWay_q <= hitWay_d;
            block_q  <= block_d;
            rdata_q  <= rdata_d;
            if (fillEn) begin
                tag_q[victim][setIdx]   <= reqTag;
                valid_q[victim][setIdx] <= 1'b1;
            end
            if (lruEn) begin
                lru_q[setIdx] <= ~hitWay_q;
            end
        end
    end

`ifdef CACHE_STATS_EN
    logic [CNT_W-1:0] hitCount_q, missCount_q;

    // Each request passes through TAG exactly once, so count there; counters stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hitCount_q  <= '0;
            missCount_q <= '0;
        end else if (state_q == TAG) begin
            if (anyHit) begin
                if (hitCount_q != {CNT_W{1'b1}}) hitCount_q <= hitCount_q + CNT_W'(1);
            end else begin
                if (missCount_q != {CNT_W{1'b1}}) missCount_q <= missCount_q + CNT_W'(1);
            end
        end
    end

    assign hit_count  = hitCount_q;
    assign miss_count = missCount_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl
// Drives cache_ctrl with directed and randomized loads/stores. The bench
// provides the way array and a memory with random acknowledge latency, and
// predicts every result from a set-associative cache model (tags, valid bits,
// LRU, backing memory) kept here.
`timescale 1ns/1ps
module tb_cache_ctrl;

    localparam int TAG_W    = 24;
    localparam int CNT_W    = 4;
    localparam int MAX_WAIT = 200;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cpu_req;
    logic             cpu_we;
    logic [31:0]      cpu_addr;
    logic [31:0]      cpu_wdata;
    logic             cpu_ready;
    logic [31:0]      cpu_rdata;
    logic [2:0]       way_index;
    logic [1:0]       way_write;
    logic [1:0]       way_wf;
    logic [255:0]     way_inblock;
    logic [255:0]     way_outblock;
    logic             mem_req;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic             mem_ack;
    logic [255:0]     mem_rdata;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;

    cache_ctrl #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .way_index(way_index), .way_write(way_write), .way_wf(way_wf),
        .way_inblock(way_inblock), .way_outblock(way_outblock),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: backing memory (sparse), cache directory, statistics.
    logic [31:0] refMem [int unsigned];
    logic [23:0] refTag [2][8];
    bit          refValid [2][8];
    bit          refLru [8];
    int          refHits = 0;
    int          refMisses = 0;
    logic [31:0] lastLoad = '0;

    // Observations gathered by the memory responder and way-array monitor.
    bit          ackHold = 1'b0;
    int          ackDelay = 1;
    int          reqCycles = 0;
    int          memTxCount = 0;
    int          memReqCycles = 0;
    logic [31:0] memTxAddr = '0;
    logic [31:0] memTxData = '0;
    logic        memTxWe = 1'b0;
    int          wayWriteCount = 0;
    int          overlapCount = 0;
    logic [1:0]  lastWayWrite = '0;
    logic [255:0] lastInblock = '0;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        if (refMem.exists(wa)) return refMem[wa];
        return (wa * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
    endfunction

    function automatic logic [255:0] blockOf(input logic [31:0] a);
        logic [255:0] b;
        b = '0;
        for (int w = 0; w < 8; w++) begin
            b[w*32 +: 32] = memWord({a[31:5], w[2:0], 2'b00});
        end
        return b;
    endfunction

    // Way array: synchronous write, combinational read selected by WF.
    logic [255:0] wayMem [2][8];
    assign way_outblock = (way_wf == 2'b10) ? wayMem[1][way_index] : wayMem[0][way_index];

    always @(posedge clk) begin
        if (way_write[0]) wayMem[0][way_index] <= way_inblock;
        if (way_write[1]) wayMem[1][way_index] <= way_inblock;
    end

    // Memory responder: acknowledges after ackDelay request cycles unless held off.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (rst_n && mem_req) begin
                memReqCycles++;
                reqCycles++;
                if (!ackHold && reqCycles >= ackDelay) begin
                    mem_ack    = 1'b1;
                    memTxCount++;
                    memTxAddr  = mem_addr;
                    memTxWe    = mem_we;
                    memTxData  = mem_wdata;
                    if (!mem_we) mem_rdata = blockOf(mem_addr);
                    reqCycles  = 0;
                end
            end else begin
                reqCycles = 0;
            end
        end
    end

    // Way-array monitor: sampled after the responder has settled mem_ack.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                if (way_write != 2'b00) begin
                    wayWriteCount++;
                    lastWayWrite = way_write;
                    lastInblock  = way_inblock;
                end
                if (way_write != 2'b00 && way_wf != 2'b00) overlapCount++;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [255:0] observed,
                               input logic [255:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
        end
    endtask

    task automatic checkCounters(input string name);
        int expHit;
        int expMiss;
`ifdef CACHE_STATS_EN
        expHit  = (refHits > CNT_MAX) ? CNT_MAX : refHits;
        expMiss = (refMisses > CNT_MAX) ? CNT_MAX : refMisses;
`else
        expHit  = 0;
        expMiss = 0;
`endif
        checkOutput({name, "_hitCount"}, 256'(hit_count), 256'(expHit));
        checkOutput({name, "_missCount"}, 256'(miss_count), 256'(expMiss));
    endtask

    // One CPU transaction: predict with the model, drive it, compare everything observed.
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] data);
        logic [2:0]   idx;
        logic [23:0]  tg;
        bit           h0, h1, isHit;
        logic         way;
        int           n, lat, expLat, expTx, expWW;
        bit           done;
        logic [31:0]  expMemAddr;
        logic [255:0] expBlk;

        idx   = addr[7:5];
        tg    = addr[31:8];
        h0    = refValid[0][idx] && (refTag[0][idx] == tg);
        h1    = refValid[1][idx] && (refTag[1][idx] == tg);
        isHit = h0 || h1;
        way   = h0 ? 1'b0 : 1'b1;
        if (!isHit && !we) begin
            way = !refValid[0][idx] ? 1'b0 : (!refValid[1][idx] ? 1'b1 : refLru[idx]);
        end
        n = $urandom_range(1, 4);
        // Cycle counts: load hit TAG,ACCESS,DONE; store hit adds MERGE and N MEMWR;
        // store miss TAG, N MEMWR, DONE; load miss TAG, N FILL, ACCESS, DONE.
        if (isHit && !we)      begin expLat = 3;     expTx = 0; expWW = 0; end
        else if (isHit && we)  begin expLat = 4 + n; expTx = 1; expWW = 1; end
        else if (we)           begin expLat = 2 + n; expTx = 1; expWW = 0; end
        else                   begin expLat = 3 + n; expTx = 1; expWW = 1; end
        expMemAddr = we ? {addr[31:2], 2'b00} : {addr[31:5], 5'd0};

        if (isHit) refHits++; else refMisses++;
        if (we) refMem[{addr[31:2], 2'b00}] = data;
        if (!isHit && !we) begin
            refTag[way][idx]   = tg;
            refValid[way][idx] = 1'b1;
        end
        if (isHit || !we) refLru[idx] = ~way;
        if (!we) lastLoad = memWord(addr);
        expBlk = blockOf(addr);

        @(negedge clk);
        ackDelay      = n;
        memTxCount    = 0;
        memReqCycles  = 0;
        wayWriteCount = 0;
        overlapCount  = 0;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = data;
        lat  = 0;
        done = 1'b0;
        while (!done && lat < MAX_WAIT) begin
            @(negedge clk);
            lat++;
            if (cpu_ready) done = 1'b1;
        end
        cpu_req = 1'b0;

        checkOutput("latency", 256'(lat), 256'(expLat));
        checkOutput("memTxCount", 256'(memTxCount), 256'(expTx));
        checkOutput("memReqCycles", 256'(memReqCycles), 256'(expTx != 0 ? n : 0));
        if (expTx != 0) begin
            checkOutput("memAddr", 256'(memTxAddr), 256'(expMemAddr));
            checkOutput("memWe", 256'(memTxWe), 256'(we));
            if (we) checkOutput("memWdata", 256'(memTxData), 256'(data));
        end
        checkOutput("wayWriteCount", 256'(wayWriteCount), 256'(expWW));
        if (expWW != 0) begin
            checkOutput("wayWriteSel", 256'(lastWayWrite), 256'(way ? 2'b10 : 2'b01));
            checkOutput("wayInblock", lastInblock, expBlk);
        end
        checkOutput("writeWfOverlap", 256'(overlapCount), 256'(0));
        checkOutput("cpuRdata", 256'(cpu_rdata), 256'(lastLoad));
        checkCounters("op");
    endtask

    task automatic resetModel();
        for (int w = 0; w < 2; w++) begin
            for (int s = 0; s < 8; s++) begin
                refValid[w][s] = 1'b0;
                refTag[w][s]   = '0;
            end
        end
        for (int s = 0; s < 8; s++) refLru[s] = 1'b0;
        refHits   = 0;
        refMisses = 0;
        lastLoad  = '0;
    endtask

    initial begin
        int          waitCnt;
        logic [23:0] rTag;
        logic [31:0] rAddr;
        logic        rWe;

        resetModel();
        refMem[32'h0000_0104] = 32'hDEAD_BEEF;
        rst_n     = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;

        #12;
        checkOutput("rst_cpuReady", 256'(cpu_ready), 256'(0));
        checkOutput("rst_cpuRdata", 256'(cpu_rdata), 256'(0));
        checkOutput("rst_memReq", 256'(mem_req), 256'(0));
        checkOutput("rst_memAddr", 256'(mem_addr), 256'(0));
        checkOutput("rst_memWdata", 256'(mem_wdata), 256'(0));
        checkOutput("rst_wayWrite", 256'(way_write), 256'(0));
        checkOutput("rst_wayWf", 256'(way_wf), 256'(0));
        checkOutput("rst_wayInblock", way_inblock, 256'(0));
        checkOutput("rst_wayIndex", 256'(way_index), 256'(0));
        checkCounters("rst");
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed sequence");
        applyStimulus(1'b0, 32'h0000_0104, 32'h0);
        checkOutput("dir_missRdata", 256'(cpu_rdata), 256'(32'hDEAD_BEEF));
        checkOutput("dir_fillAddr", 256'(memTxAddr), 256'(32'h0000_0100));
        checkOutput("dir_fillWay0", 256'(lastWayWrite), 256'(2'b01));
        applyStimulus(1'b0, 32'h0000_0104, 32'h0);
        checkOutput("dir_hitRdata", 256'(cpu_rdata), 256'(32'hDEAD_BEEF));
        applyStimulus(1'b1, 32'h0000_0108, 32'h1234_5678);
        checkOutput("dir_storeAddr", 256'(memTxAddr), 256'(32'h0000_0108));
        applyStimulus(1'b0, 32'h0000_0108, 32'h0);
        checkOutput("dir_storeReadback", 256'(cpu_rdata), 256'(32'h1234_5678));
        applyStimulus(1'b0, 32'h0000_0100, 32'h0);
        applyStimulus(1'b0, 32'h0000_1100, 32'h0);
        applyStimulus(1'b0, 32'h0000_0100, 32'h0);
        applyStimulus(1'b0, 32'h0000_2100, 32'h0);
        applyStimulus(1'b0, 32'h0000_1100, 32'h0);
        applyStimulus(1'b1, 32'h0000_3100, 32'hCAFE_F00D);
        applyStimulus(1'b0, 32'h0000_0100, 32'h0);

        $display("[TB] randomized sequence");
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0:       rTag = 24'h000001;
                1:       rTag = 24'h000011;
                2:       rTag = 24'h000021;
                default: rTag = 24'hABCDE0;
            endcase
            rAddr = {rTag, 2'b00, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                     2'($urandom_range(0, 3))};
            rWe   = ($urandom_range(0, 2) == 0);
            applyStimulus(rWe, rAddr, $urandom);
        end

        $display("[TB] reset during refill");
        @(negedge clk);
        ackHold  = 1'b1;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h0000_5104;
        waitCnt  = 0;
        while (!mem_req && waitCnt < MAX_WAIT) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("rfill_memReqSeen", 256'(mem_req), 256'(1));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rfill_memReq", 256'(mem_req), 256'(0));
        checkOutput("rfill_memAddr", 256'(mem_addr), 256'(0));
        checkOutput("rfill_cpuReady", 256'(cpu_ready), 256'(0));
        checkOutput("rfill_cpuRdata", 256'(cpu_rdata), 256'(0));
        checkOutput("rfill_wayWrite", 256'(way_write), 256'(0));
        cpu_req = 1'b0;
        ackHold = 1'b0;
        resetModel();
        checkCounters("rfill");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 32'h0000_5104, 32'h0);
        checkOutput("rfill_reloadMiss", 256'(memTxCount), 256'(1));
        applyStimulus(1'b0, 32'h0000_0104, 32'h0);
        checkOutput("rfill_oldLineMiss", 256'(memTxCount), 256'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
